uart_tx: RTL and testbench

- Asynchronous serial (UART) transmitter, 8N1 framing: 1 start bit, PAYLOAD_BITS data bits LSB first, no parity, STOP_BITS stop bits.
- Accepts a byte through a level enable and signals "busy" while the frame is on the line.
- Sits between a byte-producing host and the external TX pin.
- Bit timing is derived from the system clock by an integer cycle counter.

---
 rtl/uart_tx.sv | 131 +++++++++++++
 tb/tb_uart_tx.sv | 252 +++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx.sv
// uart_tx: 8N1-style serial transmitter with level-enable byte intake.
// Bit timing comes from an integer clock-cycle divider.
`timescale 1ns/1ps
module uart_tx #(
  parameter int BIT_RATE     = 9600,
  parameter int CLK_HZ       = 50_000_000,
  parameter int PAYLOAD_BITS = 8,
  parameter int STOP_BITS    = 1
) (
  input  logic                    clk,
  input  logic                    resetn,
  output logic                    uart_txd,
  output logic                    uart_tx_busy,
  input  logic                    uart_tx_en,
  input  logic [PAYLOAD_BITS-1:0] uart_tx_data
);

  localparam int CYCLES_PER_BIT = CLK_HZ / BIT_RATE;
  localparam int CW = $clog2(CYCLES_PER_BIT + 1);
  localparam int IW = $clog2(PAYLOAD_BITS + 1);
  localparam int SW = $clog2(STOP_BITS + 1);

  localparam logic [CW-1:0] CNT_LAST  = CW'(CYCLES_PER_BIT - 1);
  localparam logic [IW-1:0] IDX_LAST  = IW'(PAYLOAD_BITS - 1);
  localparam logic [SW-1:0] STOP_LAST = SW'(STOP_BITS - 1);

  typedef enum logic [1:0] {
    IDLE,
    START,
    DATA,
    STOP
  } state_t;

  state_t                  state;
  state_t                  state_n;
  logic [CW-1:0]           cnt;
  logic [CW-1:0]           cnt_n;
  logic [IW-1:0]           idx;
  logic [IW-1:0]           idx_n;
  logic [SW-1:0]           sbit;
  logic [SW-1:0]           sbit_n;
  logic [PAYLOAD_BITS-1:0] data;
  logic [PAYLOAD_BITS-1:0] data_n;
  logic                    txd_n;
  logic                    bit_done;

  assign bit_done     = (cnt == CNT_LAST);
  assign uart_tx_busy = (state != IDLE);

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state    <= IDLE;
      cnt      <= '0;
      idx      <= '0;
      sbit     <= '0;
      data     <= '0;
      uart_txd <= 1'b1;
    end else begin
      state    <= state_n;
      cnt      <= cnt_n;
      idx      <= idx_n;
      sbit     <= sbit_n;
      data     <= data_n;
      uart_txd <= txd_n;
    end
  end

  // The line bit is computed one cycle ahead so uart_txd stays a flop.
  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    idx_n   = idx;
    sbit_n  = sbit;
    data_n  = data;
    txd_n   = uart_txd;
    unique case (state)
      IDLE: begin
        txd_n  = 1'b1;
        cnt_n  = '0;
        idx_n  = '0;
        sbit_n = '0;
        if (uart_tx_en) begin
          data_n  = uart_tx_data;
          txd_n   = 1'b0;
          state_n = START;
        end
      end
      START: begin
        if (bit_done) begin
          cnt_n   = '0;
          idx_n   = '0;
          txd_n   = data[0];
          state_n = DATA;
        end else begin
          cnt_n = cnt + 1'b1;
        end
      end
      DATA: begin
        if (bit_done) begin
          cnt_n = '0;
          if (idx == IDX_LAST) begin
            txd_n   = 1'b1;
            sbit_n  = '0;
            state_n = STOP;
          end else begin
            // bit[idx] always sits in data[0]; shift the next one down
            idx_n  = idx + 1'b1;
            data_n = data >> 1;
            txd_n  = data[1];
          end
        end else begin
          cnt_n = cnt + 1'b1;
        end
      end
      STOP: begin
        txd_n = 1'b1;
        if (bit_done) begin
          cnt_n = '0;
          if (sbit == STOP_LAST) begin
            state_n = IDLE;
          end else begin
            sbit_n = sbit + 1'b1;
          end
        end else begin
          cnt_n = cnt + 1'b1;
        end
      end
    endcase
  end

endmodule

// File: tb/tb_uart_tx.sv
// tb_uart_tx: table, directed and random checks of uart_tx framing
// against a slot-based model of the serial line.
`timescale 1ns/1ps
module tb_uart_tx;

  logic       clk = 1'b0;
  logic       resetn = 1'b0;
  logic       en_d, en_f, en_p;
  logic [7:0] dat_d, dat_f, dat_p;
  logic       txd_d, txd_f, txd_p;
  logic       busy_d, busy_f, busy_p;
  int         checks = 0;
  int         failures = 0;
  int         sel = 1;
  logic       txd_s, busy_s;

  always #10 clk = ~clk;

  uart_tx dut_def (
    .clk(clk), .resetn(resetn),
    .uart_txd(txd_d), .uart_tx_busy(busy_d),
    .uart_tx_en(en_d), .uart_tx_data(dat_d)
  );

  uart_tx #(.BIT_RATE(5_000_000)) dut_fast (
    .clk(clk), .resetn(resetn),
    .uart_txd(txd_f), .uart_tx_busy(busy_f),
    .uart_tx_en(en_f), .uart_tx_data(dat_f)
  );

  uart_tx #(.BIT_RATE(115200)) dut_434 (
    .clk(clk), .resetn(resetn),
    .uart_txd(txd_p), .uart_tx_busy(busy_p),
    .uart_tx_en(en_p), .uart_tx_data(dat_p)
  );

  always_comb begin
    case (sel)
      0:       begin txd_s = txd_d; busy_s = busy_d; end
      1:       begin txd_s = txd_f; busy_s = busy_f; end
      default: begin txd_s = txd_p; busy_s = busy_p; end
    endcase
  end

  // Line level t cycles after the acceptance edge: slot 0 start,
  // slots 1..8 data LSB first, then stop/idle high.
  function automatic logic exp_txd(int t, int cpb, logic [7:0] b);
    int slot;
    slot = t / cpb;
    if (slot == 0) return 1'b0;
    if (slot <= 8) return b[slot-1];
    return 1'b1;
  endfunction

  function automatic logic exp_busy(int t, int cpb);
    return (t < 10 * cpb);
  endfunction

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // Entered #1 after the acceptance edge; leaves #1 after the edge
  // that returns the DUT to idle.
  task automatic run_frame(input string name, input int cpb,
                           input logic [7:0] b, input bit mess,
                           output logic [9:0] mid);
    int   bad_t;
    logic at, ab, et, eb;
    bad_t = -1;
    at = 1'b0;
    ab = 1'b0;
    mid = '0;
    for (int t = 0; t <= 10 * cpb; t++) begin
      et = exp_txd(t, cpb, b);
      eb = exp_busy(t, cpb);
      if (bad_t < 0 && (txd_s !== et || busy_s !== eb)) begin
        bad_t = t;
        at = txd_s;
        ab = busy_s;
      end
      if (t < 10 * cpb && (t % cpb) == cpb / 2) mid[t/cpb] = txd_s;
      if (mess) begin
        if (t == 3 * cpb + 2) begin dat_f = 8'hFF; en_f = 1'b0; end
        if (t == 5 * cpb) en_f = 1'b1;
        if (t == 7 * cpb) en_f = 1'b0;
      end
      if (t < 10 * cpb) begin
        @(posedge clk);
        #1;
      end
    end
    checks++;
    if (bad_t >= 0) begin
      failures++;
      $display("FAIL %s byte=%0h cycle=%0d actual txd=%0b busy=%0b required txd=%0b busy=%0b",
               name, b, bad_t, at, ab, exp_txd(bad_t, cpb, b),
               exp_busy(bad_t, cpb));
    end
  endtask

  typedef struct {
    logic [7:0] data;
    logic [9:0] frame;
  } vec_t;

  vec_t       vecs[6];
  logic [9:0] mid;
  logic [7:0] b;
  int         n;

  initial begin
    vecs[0] = '{8'h00, 10'b1000000000};
    vecs[1] = '{8'hFF, 10'b1111111110};
    vecs[2] = '{8'h01, 10'b1000000010};
    vecs[3] = '{8'h80, 10'b1100000000};
    vecs[4] = '{8'hA5, 10'b1101001010};
    vecs[5] = '{8'h3C, 10'b1001111000};

    en_d = 1'b0; en_f = 1'b0; en_p = 1'b0;
    dat_d = '0; dat_f = '0; dat_p = '0;

    resetn = 1'b0;
    #35;
    check("rst_txd", txd_d, 1);
    check("rst_busy", busy_d, 0);
    check("rst_txd_fast", txd_f, 1);
    #5 resetn = 1'b1;
    repeat (5) @(posedge clk);
    #1;
    check("idle_txd", txd_d, 1);
    check("idle_busy", busy_d, 0);

    sel = 1;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      dat_f = vecs[i].data;
      en_f = 1'b1;
      @(posedge clk);
      #1;
      en_f = 1'b0;
      run_frame("vec_model", 10, vecs[i].data, 1'b0, mid);
      check("vec_frame", mid, vecs[i].frame);
    end

    @(negedge clk);
    dat_f = 8'($urandom);
    en_f = 1'b1;
    @(posedge clk);
    #1;
    for (int k = 0; k < 20; k++) begin
      b = dat_f;
      run_frame("b2b_frame", 10, b, 1'b0, mid);
      if (k == 19) begin
        en_f = 1'b0;
      end else begin
        dat_f = 8'($urandom);
        @(posedge clk);
        #1;
        check("b2b_busy_rise", busy_f, 1);
      end
    end
    @(posedge clk);
    #1;
    check("b2b_stop_idle", busy_f, 0);

    @(negedge clk);
    dat_f = 8'h5A;
    en_f = 1'b1;
    @(posedge clk);
    #1;
    en_f = 1'b0;
    run_frame("mid_change", 10, 8'h5A, 1'b1, mid);
    check("mid_change_bits", mid, 10'b1010110100);
    @(posedge clk);
    #1;
    check("no_restart", busy_f, 0);

    @(negedge clk);
    dat_f = 8'hC3;
    en_f = 1'b1;
    @(posedge clk);
    #1;
    en_f = 1'b0;
    repeat (40) @(posedge clk);
    #5;
    resetn = 1'b0;
    #1;
    check("async_rst_txd", txd_f, 1);
    check("async_rst_busy", busy_f, 0);
    @(negedge clk);
    dat_f = 8'h96;
    en_f = 1'b1;
    resetn = 1'b1;
    @(posedge clk);
    #1;
    en_f = 1'b0;
    run_frame("post_rst", 10, 8'h96, 1'b0, mid);
    check("post_rst_bits", mid, 10'b1100101100);

    sel = 0;
    @(negedge clk);
    check("a5_pre_busy", busy_d, 0);
    dat_d = 8'hA5;
    en_d = 1'b1;
    @(posedge clk);
    #1;
    en_d = 1'b0;
    run_frame("a5_frame", 5208, 8'hA5, 1'b0, mid);
    check("a5_bits", mid, 10'b1101001010);

    check("cpb_def", dut_def.CYCLES_PER_BIT, 5208);
    check("cpb_434", dut_434.CYCLES_PER_BIT, 434);
    sel = 2;
    @(negedge clk);
    dat_p = 8'h01;
    en_p = 1'b1;
    @(posedge clk);
    #1;
    en_p = 1'b0;
    n = 0;
    while (txd_p === 1'b0 && n < 1000) begin
      @(posedge clk);
      #1;
      n++;
    end
    check("start_period_434", n, 434);
    n = 0;
    while (txd_p === 1'b1 && n < 1000) begin
      @(posedge clk);
      #1;
      n++;
    end
    check("bit0_period_434", n, 434);
    n = 0;
    while (busy_p === 1'b1 && n < 5000) begin
      @(posedge clk);
      #1;
      n++;
    end
    check("frame_rest_434", n, 434 * 8);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
